// File: rtl/wave_dispatcher.sv
// wave_dispatcher: splits one thread block into wavefronts and issues them to
// NUM_SIMDS SIMD units in lowest-index-idle order, then reports block completion.
module wave_dispatcher #(
  parameter int NUM_SIMDS = 2,
  parameter int WAVE_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [31:0]                 num_threads,
  input  logic [31:0]                 block_dim,
  input  logic                        block_start,
  input  logic signed [31:0]          block_id_in,
  output logic                        block_busy,
  output logic                        block_done,
  output logic signed [31:0]          block_id,
  output logic [31:0]                 num_waves_in_block,
  output logic signed [31:0]          wave_id [NUM_SIMDS-1:0],
  output logic [NUM_SIMDS-1:0]        simd_ready,
  output logic [NUM_SIMDS-1:0]        simd_start,
  output logic [NUM_SIMDS-1:0]        simd_working,
  input  logic [NUM_SIMDS-1:0]        simd_done
);

  typedef enum logic [1:0] {T_IDLE, T_CALC, T_DISPATCH, T_DONE} top_state_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WORK} simd_state_e;

  localparam logic signed [63:0] WAVE_SIZE_W = 64'(WAVE_SIZE);

  top_state_e           top_q;
  simd_state_e          simd_state_q [NUM_SIMDS];
  logic                 busy_q;
  logic                 done_q;
  logic signed [31:0]   block_id_q;
  logic [31:0]          num_waves_q;
  logic [31:0]          next_wave_q;
  logic signed [31:0]   wave_id_q [NUM_SIMDS];
  logic [NUM_SIMDS-1:0] ready_q;
  logic [NUM_SIMDS-1:0] start_q;
  logic [NUM_SIMDS-1:0] working_q;

  logic signed [63:0]   remaining;
  logic signed [63:0]   threads;
  logic [31:0]          num_waves_d;
  logic [NUM_SIMDS-1:0] idle;
  logic [NUM_SIMDS-1:0] grant;
  logic                 can_dispatch;
  logic signed [31:0]   dispatch_wave;

  // Thread count of the latched block, clamped to [0, block_dim], rounded up to waves.
  always_comb begin
    remaining = $signed({32'd0, num_threads})
              - $signed({{32{block_id_q[31]}}, block_id_q}) * $signed({32'd0, block_dim});
    if (remaining <= 64'sd0) begin
      threads = '0;
    end else if (remaining >= $signed({32'd0, block_dim})) begin
      threads = $signed({32'd0, block_dim});
    end else begin
      threads = remaining;
    end
    num_waves_d = 32'((threads + WAVE_SIZE_W - 64'sd1) / WAVE_SIZE_W);
  end

  for (genvar gi = 0; gi < NUM_SIMDS; gi++) begin : g_simd
    assign idle[gi]    = (simd_state_q[gi] == S_IDLE);
    assign wave_id[gi] = wave_id_q[gi];
  end

  // Wave 0 is issued straight out of CALC so the first start lands two cycles after acceptance.
  always_comb begin
    can_dispatch  = ((top_q == T_CALC) && (num_waves_d != '0)) ||
                    ((top_q == T_DISPATCH) && (next_wave_q < num_waves_q));
    dispatch_wave = (top_q == T_CALC) ? '0 : $signed(next_wave_q);
    grant         = can_dispatch ? (idle & (~idle + 1'b1)) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      top_q       <= T_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      block_id_q  <= '0;
      num_waves_q <= '0;
      next_wave_q <= '0;
      ready_q     <= '1;
      start_q     <= '0;
      working_q   <= '0;
      for (int i = 0; i < NUM_SIMDS; i++) begin
        simd_state_q[i] <= S_IDLE;
        wave_id_q[i]    <= '0;
      end
    end else if (enable) begin
      case (top_q)
        T_IDLE: begin
          if (block_start) begin
            block_id_q <= block_id_in;
            busy_q     <= 1'b1;
            top_q      <= T_CALC;
          end
        end
        T_CALC: begin
          num_waves_q <= num_waves_d;
          if (num_waves_d == '0) begin
            next_wave_q <= '0;
            done_q      <= 1'b1;
            top_q       <= T_DONE;
          end else begin
            next_wave_q <= 32'd1;
            top_q       <= T_DISPATCH;
          end
        end
        T_DISPATCH: begin
          if (|grant) begin
            next_wave_q <= next_wave_q + 32'd1;
          end else if ((next_wave_q == num_waves_q) && (&idle)) begin
            done_q <= 1'b1;
            top_q  <= T_DONE;
          end
        end
        T_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          top_q  <= T_IDLE;
        end
        default: top_q <= T_IDLE;
      endcase

      for (int i = 0; i < NUM_SIMDS; i++) begin
        case (simd_state_q[i])
          S_IDLE: begin
            if (grant[i]) begin
              simd_state_q[i] <= S_START;
              wave_id_q[i]    <= dispatch_wave;
              ready_q[i]      <= 1'b0;
              start_q[i]      <= 1'b1;
            end
          end
          S_START: begin
            simd_state_q[i] <= S_WORK;
            start_q[i]      <= 1'b0;
            working_q[i]    <= 1'b1;
          end
          S_WORK: begin
            if (simd_done[i]) begin
              simd_state_q[i] <= S_IDLE;
              working_q[i]    <= 1'b0;
              ready_q[i]      <= 1'b1;
            end
          end
          default: simd_state_q[i] <= S_IDLE;
        endcase
      end
    end
  end

  assign block_busy         = busy_q;
  assign block_done         = done_q;
  assign block_id           = block_id_q;
  assign num_waves_in_block = num_waves_q;
  assign simd_ready         = ready_q;
  assign simd_start         = start_q;
  assign simd_working       = working_q;

endmodule
